rvh_lsu_l1d_st_req_enc: RTL and testbench

Store-side request encoder and issue buffer between the LSU store pipe and the L1D. It accepts decoded store, SC and AMO micro-ops, encodes each into the 5-bit STU opcode consumed by the L1D request-type decoder, and buffers them in an in-order FIFO. It then issues them to the L1D over a valid/ready handshake. Atomics (SC/AMO) are serialized: after one issues, nothing further issues until its response returns.

---
 rtl/rvh_l1d_pkg.sv | 63 ++++++
 rtl/rvh_lsu_st_opcode_enc.sv | 48 ++++
 rtl/rvh_lsu_l1d_st_req_enc.sv | 165 ++++++++++++++++
 tb/tb_rvh_lsu_l1d_st_req_enc.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rvh_l1d_pkg.sv
// L1D request-side shared types and STU opcode map.
// Used by the LSU store-side request encoder and issue buffer.
package rvh_l1d_pkg;

    localparam int LDU_OP_WIDTH = 4;
    localparam int STU_OP_WIDTH = 5;

    localparam int L1D_PADDR_WIDTH   = 56;
    localparam int L1D_XLEN          = 64;
    localparam int L1D_ROB_TAG_WIDTH = 7;

    localparam logic [STU_OP_WIDTH-1:0] STU_SB       = 5'd0;
    localparam logic [STU_OP_WIDTH-1:0] STU_SH       = 5'd1;
    localparam logic [STU_OP_WIDTH-1:0] STU_SW       = 5'd2;
    localparam logic [STU_OP_WIDTH-1:0] STU_SD       = 5'd3;
    localparam logic [STU_OP_WIDTH-1:0] STU_SC_W     = 5'd5;
    localparam logic [STU_OP_WIDTH-1:0] STU_SC_D     = 5'd6;
    localparam logic [STU_OP_WIDTH-1:0] STU_AMOSWAP_W = 5'd7;
    localparam logic [STU_OP_WIDTH-1:0] STU_AMOSWAP_D = 5'd8;
    localparam logic [STU_OP_WIDTH-1:0] STU_AMOADD_W = 5'd9;
    localparam logic [STU_OP_WIDTH-1:0] STU_AMOADD_D = 5'd10;
    localparam logic [STU_OP_WIDTH-1:0] STU_AMOAND_W = 5'd11;
    localparam logic [STU_OP_WIDTH-1:0] STU_AMOAND_D = 5'd12;
    localparam logic [STU_OP_WIDTH-1:0] STU_AMOOR_W  = 5'd13;
    localparam logic [STU_OP_WIDTH-1:0] STU_AMOOR_D  = 5'd14;
    localparam logic [STU_OP_WIDTH-1:0] STU_AMOXOR_W = 5'd15;
    localparam logic [STU_OP_WIDTH-1:0] STU_AMOXOR_D = 5'd16;
    localparam logic [STU_OP_WIDTH-1:0] STU_AMOMAX_W = 5'd17;
    localparam logic [STU_OP_WIDTH-1:0] STU_AMOMAX_D = 5'd18;
    localparam logic [STU_OP_WIDTH-1:0] STU_AMOMAXU_W = 5'd19;
    localparam logic [STU_OP_WIDTH-1:0] STU_AMOMAXU_D = 5'd20;
    localparam logic [STU_OP_WIDTH-1:0] STU_AMOMIN_W = 5'd21;
    localparam logic [STU_OP_WIDTH-1:0] STU_AMOMIN_D = 5'd22;
    localparam logic [STU_OP_WIDTH-1:0] STU_AMOMINU_W = 5'd23;
    localparam logic [STU_OP_WIDTH-1:0] STU_AMOMINU_D = 5'd24;

    typedef enum logic [1:0] {
        REQ_STORE = 2'd0,
        REQ_SC    = 2'd1,
        REQ_AMO   = 2'd2,
        REQ_RSVD  = 2'd3
    } st_req_kind_e;

    typedef enum logic [3:0] {
        AMO_SWAP = 4'd0,
        AMO_ADD  = 4'd1,
        AMO_AND  = 4'd2,
        AMO_OR   = 4'd3,
        AMO_XOR  = 4'd4,
        AMO_MAX  = 4'd5,
        AMO_MAXU = 4'd6,
        AMO_MIN  = 4'd7,
        AMO_MINU = 4'd8
    } amo_func_e;

    typedef struct packed {
        logic [STU_OP_WIDTH-1:0]      opcode;
        logic [L1D_PADDR_WIDTH-1:0]   paddr;
        logic [L1D_XLEN-1:0]          data;
        logic [L1D_ROB_TAG_WIDTH-1:0] rob_tag;
    } st_req_t;

endpackage

// File: rtl/rvh_lsu_st_opcode_enc.sv
// Combinational {kind, func, size} to STU opcode encoder.
// Flags combinations the L1D cannot execute as illegal.
module rvh_lsu_st_opcode_enc
    import rvh_l1d_pkg::*;
(
    input  logic [1:0]              i_kind,
    input  logic [3:0]              i_func,
    input  logic [1:0]              i_size,
    output logic [STU_OP_WIDTH-1:0] o_opcode,
    output logic                    o_illegal
);

    st_req_kind_e w_kind;

    assign w_kind = st_req_kind_e'(i_kind);

    // AMO opcodes interleave W/D per function: base + 2*func + is_double
    always_comb begin
        o_opcode  = '0;
        o_illegal = 1'b0;
        unique case (w_kind)
            REQ_STORE: begin
                o_opcode = {3'b000, i_size};
            end
            REQ_SC: begin
                if (i_size == 2'd2) begin
                    o_opcode = STU_SC_W;
                end else if (i_size == 2'd3) begin
                    o_opcode = STU_SC_D;
                end else begin
                    o_illegal = 1'b1;
                end
            end
            REQ_AMO: begin
                if (!i_size[1] || (i_func > 4'(AMO_MINU))) begin
                    o_illegal = 1'b1;
                end else begin
                    o_opcode = STU_AMOSWAP_W + {i_func, 1'b0}
                             + {4'b0000, i_size[0]};
                end
            end
            REQ_RSVD: begin
                o_illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/rvh_lsu_l1d_st_req_enc.sv
// Store-side request encoder and in-order issue buffer to the L1D.
// SC/AMO block further issue until their response returns.
module rvh_lsu_l1d_st_req_enc
    import rvh_l1d_pkg::*;
#(
    parameter int ENTRY_COUNT   = 4,
    parameter int PADDR_WIDTH   = 56,
    parameter int XLEN          = 64,
    parameter int ROB_TAG_WIDTH = 7
)(
    input  logic                     clk,
    input  logic                     rst_n,

    input  logic                     lsu_req_vld_i,
    output logic                     lsu_req_rdy_o,
    input  logic [1:0]               lsu_req_kind_i,
    input  logic [3:0]               lsu_req_amo_func_i,
    input  logic [1:0]               lsu_req_size_i,
    input  logic [PADDR_WIDTH-1:0]   lsu_req_paddr_i,
    input  logic [XLEN-1:0]          lsu_req_data_i,
    input  logic [ROB_TAG_WIDTH-1:0] lsu_req_rob_tag_i,
    output logic                     lsu_req_illegal_o,
    output logic [ROB_TAG_WIDTH-1:0] lsu_req_illegal_rob_tag_o,

    output logic                     ls_pipe_l1d_st_req_vld_o,
    input  logic                     ls_pipe_l1d_st_req_rdy_i,
    output logic [STU_OP_WIDTH-1:0]  ls_pipe_l1d_st_req_opcode_o,
    output logic [PADDR_WIDTH-1:0]   ls_pipe_l1d_st_req_paddr_o,
    output logic [XLEN-1:0]          ls_pipe_l1d_st_req_data_o,
    output logic [ROB_TAG_WIDTH-1:0] ls_pipe_l1d_st_req_rob_tag_o,

    input  logic                     l1d_ls_pipe_atomic_resp_vld_i
);

    localparam int PTR_W = $clog2(ENTRY_COUNT);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [0:0] ST_IDLE        = 1'b0;
    localparam logic [0:0] ST_ATOMIC_PEND = 1'b1;

    typedef struct packed {
        logic [STU_OP_WIDTH-1:0]  opcode;
        logic [PADDR_WIDTH-1:0]   paddr;
        logic [XLEN-1:0]          data;
        logic [ROB_TAG_WIDTH-1:0] rob_tag;
    } entry_t;

    entry_t                   r_fifo [ENTRY_COUNT];
    logic [PTR_W-1:0]         r_wptr;
    logic [PTR_W-1:0]         r_rptr;
    logic [CNT_W-1:0]         r_cnt;
    logic [0:0]               r_state;
    logic                     r_illegal;
    logic [ROB_TAG_WIDTH-1:0] r_illegal_tag;

    logic [STU_OP_WIDTH-1:0]  w_enc_opcode;
    logic                     w_enc_illegal;
    logic                     w_full;
    logic                     w_empty;
    logic                     w_acc;
    logic                     w_enq;
    logic                     w_deq;
    logic                     w_head_atomic;
    entry_t                   w_head;
    entry_t                   w_new;

    rvh_lsu_st_opcode_enc u_opcode_enc (
        .i_kind    (lsu_req_kind_i),
        .i_func    (lsu_req_amo_func_i),
        .i_size    (lsu_req_size_i),
        .o_opcode  (w_enc_opcode),
        .o_illegal (w_enc_illegal)
    );

    assign w_full  = (r_cnt == CNT_W'(ENTRY_COUNT));
    assign w_empty = (r_cnt == '0);
    assign w_acc   = lsu_req_vld_i & lsu_req_rdy_o;
    assign w_enq   = w_acc & ~w_enc_illegal;
    assign w_deq   = ls_pipe_l1d_st_req_vld_o & ls_pipe_l1d_st_req_rdy_i;

    assign w_head        = r_fifo[r_rptr];
    assign w_head_atomic = (w_head.opcode >= STU_SC_W);

    assign w_new.opcode  = w_enc_opcode;
    assign w_new.paddr   = lsu_req_paddr_i;
    assign w_new.data    = lsu_req_data_i;
    assign w_new.rob_tag = lsu_req_rob_tag_i;

    assign lsu_req_rdy_o             = ~w_full;
    assign lsu_req_illegal_o         = r_illegal;
    assign lsu_req_illegal_rob_tag_o = r_illegal_tag;

    assign ls_pipe_l1d_st_req_vld_o     = ~w_empty & (r_state == ST_IDLE);
    assign ls_pipe_l1d_st_req_opcode_o  = w_empty ? '0 : w_head.opcode;
    assign ls_pipe_l1d_st_req_paddr_o   = w_empty ? '0 : w_head.paddr;
    assign ls_pipe_l1d_st_req_data_o    = w_empty ? '0 : w_head.data;
    assign ls_pipe_l1d_st_req_rob_tag_o = w_empty ? '0 : w_head.rob_tag;

    // FIFO storage write on legal accept
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRY_COUNT; i++) begin
                r_fifo[i] <= '0;
            end
        end else if (w_enq) begin
            r_fifo[r_wptr] <= w_new;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
        end else begin
            if (w_enq) begin
                r_wptr <= r_wptr + PTR_W'(1);
            end
            if (w_deq) begin
                r_rptr <= r_rptr + PTR_W'(1);
            end
            unique case ({w_enq, w_deq})
                2'b10:   r_cnt <= r_cnt + CNT_W'(1);
                2'b01:   r_cnt <= r_cnt - CNT_W'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    // Atomic serialization: hold issue until the SC/AMO response
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (w_deq && w_head_atomic) begin
                        r_state <= ST_ATOMIC_PEND;
                    end
                end
                ST_ATOMIC_PEND: begin
                    if (l1d_ls_pipe_atomic_resp_vld_i) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // One-cycle illegal pulse carrying the rejected request's tag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_illegal     <= 1'b0;
            r_illegal_tag <= '0;
        end else begin
            r_illegal <= w_acc & w_enc_illegal;
            if (w_acc && w_enc_illegal) begin
                r_illegal_tag <= lsu_req_rob_tag_i;
            end
        end
    end

endmodule

// File: tb/tb_rvh_lsu_l1d_st_req_enc.sv
// Self-checking bench for the store request encoder / issue buffer.
// Table-driven encodings plus directed timing sequences.
module tb_rvh_lsu_l1d_st_req_enc;

    logic        clk;
    logic        rst_n;
    logic        req_vld;
    logic        req_rdy;
    logic [1:0]  req_kind;
    logic [3:0]  req_func;
    logic [1:0]  req_size;
    logic [55:0] req_paddr;
    logic [63:0] req_data;
    logic [6:0]  req_tag;
    logic        ill;
    logic [6:0]  ill_tag;
    logic        st_vld;
    logic        st_rdy;
    logic [4:0]  st_op;
    logic [55:0] st_paddr;
    logic [63:0] st_data;
    logic [6:0]  st_tag;
    logic        resp_vld;

    rvh_lsu_l1d_st_req_enc dut (
        .clk                           (clk),
        .rst_n                         (rst_n),
        .lsu_req_vld_i                 (req_vld),
        .lsu_req_rdy_o                 (req_rdy),
        .lsu_req_kind_i                (req_kind),
        .lsu_req_amo_func_i            (req_func),
        .lsu_req_size_i                (req_size),
        .lsu_req_paddr_i               (req_paddr),
        .lsu_req_data_i                (req_data),
        .lsu_req_rob_tag_i             (req_tag),
        .lsu_req_illegal_o             (ill),
        .lsu_req_illegal_rob_tag_o     (ill_tag),
        .ls_pipe_l1d_st_req_vld_o      (st_vld),
        .ls_pipe_l1d_st_req_rdy_i      (st_rdy),
        .ls_pipe_l1d_st_req_opcode_o   (st_op),
        .ls_pipe_l1d_st_req_paddr_o    (st_paddr),
        .ls_pipe_l1d_st_req_data_o     (st_data),
        .ls_pipe_l1d_st_req_rob_tag_o  (st_tag),
        .l1d_ls_pipe_atomic_resp_vld_i (resp_vld)
    );

    typedef struct {
        logic [4:0]  op;
        logic [55:0] paddr;
        logic [63:0] data;
        logic [6:0]  tag;
    } exp_t;

    typedef struct {
        logic [1:0] kind;
        logic [3:0] func;
        logic [1:0] size;
        logic [4:0] op;
        logic       ill;
    } vec_t;

    exp_t sb[$];
    int   hs_q[$];
    int   cyc;
    int   n_cmp;
    int   n_err;

    logic        pv;
    logic        phs;
    exp_t        pe;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Output monitor: scoreboard pop on handshake, payload stability
    always @(negedge clk) begin
        if (!rst_n) begin
            pv = 1'b0;
        end else begin
            if (pv && !phs) begin
                chk("hold_vld", st_vld, 1);
                chk("hold_op", st_op, pe.op);
                chk("hold_tag", st_tag, pe.tag);
                chk("hold_data", st_data, pe.data);
            end
            if (st_vld && st_rdy) begin
                hs_q.push_back(cyc);
                if (sb.size() == 0) begin
                    chk("unexpected_issue", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("issue_op", st_op, e.op);
                    chk("issue_paddr", st_paddr, e.paddr);
                    chk("issue_data", st_data, e.data);
                    chk("issue_tag", st_tag, e.tag);
                end
            end
            pv  = st_vld;
            phs = st_vld && st_rdy;
            pe.op    = st_op;
            pe.paddr = st_paddr;
            pe.data  = st_data;
            pe.tag   = st_tag;
        end
    end

    task automatic drv(input logic [1:0] k, input logic [3:0] f,
                       input logic [1:0] s, input logic [6:0] t,
                       input logic [4:0] op, input logic il);
        exp_t e;
        req_vld   = 1'b1;
        req_kind  = k;
        req_func  = f;
        req_size  = s;
        req_tag   = t;
        req_paddr = {40'h0, 9'h0, t} << 3;
        req_data  = {$urandom, $urandom};
        if (!il) begin
            e.op    = op;
            e.paddr = req_paddr;
            e.data  = req_data;
            e.tag   = t;
            sb.push_back(e);
        end
    endtask

    // Called just after a posedge; returns just after a posedge
    task automatic send(input logic [1:0] k, input logic [3:0] f,
                        input logic [1:0] s, input logic [6:0] t,
                        input logic [4:0] op, input logic il);
        logic ok;
        ok = 1'b0;
        drv(k, f, s, t, op, il);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (req_rdy) begin
                ok = 1'b1;
                break;
            end
        end
        chk("rdy_wait", ok, 1);
        @(posedge clk);
        #1 req_vld = 1'b0;
        @(negedge clk);
        chk("illegal_pulse", ill, il);
        if (il) chk("illegal_tag", ill_tag, t);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain();
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            #1;
            if (sb.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        chk("drain", ok, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_resp();
        resp_vld = 1'b1;
        @(posedge clk);
        #1 resp_vld = 1'b0;
    endtask

    vec_t vt[24];
    int   t0;
    int   t_resp;

    initial begin
        vt[0]  = '{2'd0, 4'd0, 2'd0, 5'd0,  1'b0};
        vt[1]  = '{2'd0, 4'd0, 2'd1, 5'd1,  1'b0};
        vt[2]  = '{2'd0, 4'd0, 2'd2, 5'd2,  1'b0};
        vt[3]  = '{2'd0, 4'd0, 2'd3, 5'd3,  1'b0};
        vt[4]  = '{2'd1, 4'd0, 2'd0, 5'd0,  1'b1};
        vt[5]  = '{2'd1, 4'd0, 2'd1, 5'd0,  1'b1};
        vt[6]  = '{2'd1, 4'd0, 2'd2, 5'd5,  1'b0};
        vt[7]  = '{2'd1, 4'd0, 2'd3, 5'd6,  1'b0};
        vt[8]  = '{2'd2, 4'd0, 2'd2, 5'd7,  1'b0};
        vt[9]  = '{2'd2, 4'd1, 2'd3, 5'd10, 1'b0};
        vt[10] = '{2'd2, 4'd2, 2'd2, 5'd11, 1'b0};
        vt[11] = '{2'd2, 4'd3, 2'd3, 5'd14, 1'b0};
        vt[12] = '{2'd2, 4'd4, 2'd2, 5'd15, 1'b0};
        vt[13] = '{2'd2, 4'd5, 2'd3, 5'd18, 1'b0};
        vt[14] = '{2'd2, 4'd6, 2'd2, 5'd19, 1'b0};
        vt[15] = '{2'd2, 4'd7, 2'd3, 5'd22, 1'b0};
        vt[16] = '{2'd2, 4'd8, 2'd2, 5'd23, 1'b0};
        vt[17] = '{2'd2, 4'd8, 2'd3, 5'd24, 1'b0};
        vt[18] = '{2'd2, 4'd9, 2'd3, 5'd0,  1'b1};
        vt[19] = '{2'd2, 4'd15, 2'd2, 5'd0, 1'b1};
        vt[20] = '{2'd2, 4'd1, 2'd0, 5'd0,  1'b1};
        vt[21] = '{2'd2, 4'd0, 2'd1, 5'd0,  1'b1};
        vt[22] = '{2'd3, 4'd0, 2'd3, 5'd0,  1'b1};
        vt[23] = '{2'd2, 4'd6, 2'd3, 5'd20, 1'b0};

        n_cmp = 0;
        n_err = 0;
        cyc = 0;
        pv = 1'b0;
        phs = 1'b0;
        rst_n = 1'b0;
        req_vld = 1'b0;
        req_kind = '0;
        req_func = '0;
        req_size = '0;
        req_paddr = '0;
        req_data = '0;
        req_tag = '0;
        st_rdy = 1'b0;
        resp_vld = 1'b0;

        #2;
        chk("rst_rdy", req_rdy, 1);
        chk("rst_vld", st_vld, 0);
        chk("rst_ill", ill, 0);
        chk("rst_ill_tag", ill_tag, 0);
        chk("rst_op", st_op, 0);
        chk("rst_paddr", st_paddr, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        st_rdy = 1'b1;
        @(posedge clk);
        #1;

        // Back-to-back stores: one issue per cycle from T+1
        hs_q.delete();
        for (int i = 0; i < 4; i++) begin
            drv(2'd0, 4'd0, 2'(i), 7'(i + 1), 5'(i), 1'b0);
            @(posedge clk);
            #1;
            if (i == 0) t0 = cyc;
        end
        req_vld = 1'b0;
        wait_drain();
        chk("burst_cnt", hs_q.size(), 4);
        for (int i = 0; i < hs_q.size(); i++) begin
            chk("burst_cycle", hs_q[i], t0 + i);
        end

        // Encoding table; atomics are released by a response
        for (int i = 0; i < 24; i++) begin
            send(vt[i].kind, vt[i].func, vt[i].size, 7'(10 + i),
                 vt[i].op, vt[i].ill);
            if (!vt[i].ill) begin
                wait_drain();
                if (vt[i].op >= 5'd5) pulse_resp();
            end
        end

        // Response while idle is ignored; atomic blocks a later store
        pulse_resp();
        hs_q.delete();
        send(2'd2, 4'd6, 2'd3, 7'd50, 5'd20, 1'b0);
        send(2'd0, 4'd0, 2'd2, 7'd51, 5'd2, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        chk("atomic_hold_hs", hs_q.size(), 1);
        chk("atomic_hold_vld", st_vld, 0);
        chk("atomic_hold_sb", sb.size(), 1);
        resp_vld = 1'b1;
        @(posedge clk);
        #1 t_resp = cyc;
        resp_vld = 1'b0;
        wait_drain();
        chk("atomic_rel_hs", hs_q.size(), 2);
        if (hs_q.size() == 2) chk("atomic_rel_cycle", hs_q[1], t_resp);

        // Fill with L1D stalled, then one dequeue frees a slot
        st_rdy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            send(2'd0, 4'd0, 2'd2, 7'(60 + i), 5'd2, 1'b0);
        end
        chk("full_rdy", req_rdy, 0);
        drv(2'd0, 4'd0, 2'd3, 7'd64, 5'd3, 1'b0);
        st_rdy = 1'b1;
        @(negedge clk);
        chk("full_rdy_on_deq", req_rdy, 0);
        @(posedge clk);
        #1 st_rdy = 1'b0;
        @(negedge clk);
        chk("rdy_after_deq", req_rdy, 1);
        @(posedge clk);
        #1 req_vld = 1'b0;
        st_rdy = 1'b1;
        wait_drain();

        // Async reset with an atomic pending and 3 queued stores
        send(2'd2, 4'd0, 2'd2, 7'd70, 5'd7, 1'b0);
        wait_drain();
        for (int i = 0; i < 3; i++) begin
            send(2'd0, 4'd0, 2'd1, 7'(71 + i), 5'd1, 1'b0);
        end
        chk("pre_rst_sb", sb.size(), 3);
        chk("pre_rst_vld", st_vld, 0);
        send(2'd3, 4'd0, 2'd0, 7'd75, 5'd0, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_vld", st_vld, 0);
        chk("arst_rdy", req_rdy, 1);
        chk("arst_ill_tag", ill_tag, 0);
        chk("arst_op", st_op, 0);
        chk("arst_tag", st_tag, 0);
        sb.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;
        hs_q.delete();
        send(2'd0, 4'd0, 2'd3, 7'd5, 5'd3, 1'b0);
        wait_drain();
        chk("post_rst_hs", hs_q.size(), 1);

        chk("sb_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
